line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/tetris_pkg.sv | 29 ++
 rtl/row_full_detect.sv | 16 +
 rtl/line_clear_ctrl.sv | 108 ++++++++++
 tb/tb_line_clear_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared grid geometry, clear-controller state encoding and scoring helpers.
package tetris_pkg;
  localparam int ROWS_D   = 22;
  localparam int COLS_D   = 10;
  localparam int CELL_W_D = 3;

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  // Points awarded per pass; an illegal count above four scores like four.
  function automatic logic [7:0] pass_points(input logic [4:0] n);
    case (n)
      5'd0:    return 8'd0;
      5'd1:    return 8'd1;
      5'd2:    return 8'd3;
      5'd3:    return 8'd5;
      default: return 8'd8;
    endcase
  endfunction

  function automatic logic [2:0] lines_sat(input logic [4:0] n);
    return (n > 5'd4) ? 3'd4 : n[2:0];
  endfunction

  function automatic logic [7:0] score_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row test: every cell of the row holds a nonzero colour.
module row_full_detect import tetris_pkg::*; #(
  parameter int COLS   = COLS_D,
  parameter int CELL_W = CELL_W_D
) (
  input  logic [COLS*CELL_W-1:0] row,
  output logic                   full
);
  logic [COLS-1:0] nz;

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    assign nz[c] = |row[c*CELL_W +: CELL_W];
  end

  assign full = &nz;
endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear pass: scans bottom-up, compacts non-full rows downward,
// blanks the freed top rows, then reports cleared lines and updates score.
module line_clear_ctrl import tetris_pkg::*; #(
  parameter int ROWS   = ROWS_D,
  parameter int COLS   = COLS_D,
  parameter int CELL_W = CELL_W_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   score_clr,
  output logic [4:0]             rd_row,
  input  logic [COLS*CELL_W-1:0] rd_data,
  output logic                   wr_en,
  output logic [4:0]             wr_row,
  output logic [COLS*CELL_W-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             lines,
  output logic [7:0]             score
);
  localparam logic [4:0] LAST = 5'(ROWS - 1);

  state_t     state, state_nx;
  logic [4:0] src, src_nx, dst, dst_nx, cnt, cnt_nx;
  logic       full;

  row_full_detect #(.COLS(COLS), .CELL_W(CELL_W)) u_full (
    .row  (rd_data),
    .full (full)
  );

  always_comb begin
    state_nx = state;
    src_nx   = src;
    dst_nx   = dst;
    cnt_nx   = cnt;
    rd_row   = '0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          src_nx   = LAST;
          dst_nx   = LAST;
          cnt_nx   = '0;
        end
      end
      SCAN: begin
        rd_row = src;
        if (full) begin
          cnt_nx = cnt + 5'd1;
        end else begin
          dst_nx = dst - 5'd1;
          // Until the first full row is seen src==dst and the row stays put.
          if (src != dst) begin
            wr_en   = 1'b1;
            wr_row  = dst;
            wr_data = rd_data;
          end
        end
        src_nx = src - 5'd1;
        if (src == '0) begin
          src_nx   = '0;
          state_nx = (cnt_nx != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        // dst now sits cnt-1 rows from the top, so this runs cnt cycles.
        wr_en  = 1'b1;
        wr_row = dst;
        dst_nx = dst - 5'd1;
        if (dst == '0) begin
          dst_nx   = '0;
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      lines <= '0;
      score <= '0;
    end else begin
      state <= state_nx;
      src   <= src_nx;
      dst   <= dst_nx;
      cnt   <= cnt_nx;
      if (state == DONE) lines <= lines_sat(cnt);
      if (score_clr)
        score <= '0;
      else if (state == DONE)
        score <= score_add(score, pass_points(cnt));
    end
  end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench: a behavioural grid RAM feeds the controller; pass results,
// latency, write counts and scoring are compared against hand-derived values.
module tb_line_clear_ctrl;
  import tetris_pkg::*;
  localparam int ROWS = 22, COLS = 10, CELL_W = 3, RW = COLS*CELL_W;
  typedef logic [RW-1:0] row_t;

  localparam row_t FULL = {COLS{3'b101}};
  localparam row_t P    = 30'h0000_0FFF;
  localparam row_t Q    = 30'h2000_0001;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, score_clr = 1'b0;
  logic [4:0] rd_row, wr_row;
  row_t       rd_data, wr_data;
  logic       wr_en, busy, done;
  logic [2:0] lines;
  logic [7:0] score;

  row_t grid [32];
  row_t img  [32];
  row_t expg [32];
  logic load = 1'b0;
  int   wr_cnt = 0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .score_clr(score_clr),
    .rd_row(rd_row), .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .busy(busy), .done(done), .lines(lines), .score(score)
  );

  assign rd_data = grid[rd_row];

  always @(posedge clk) begin
    if (load) grid <= img;
    else if (wr_en) begin
      grid[wr_row] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < 32; r++) begin img[r] = '0; expg[r] = '0; end
  endtask

  task automatic stack_full(input int k);
    clear_img();
    for (int r = 0; r < k; r++) img[ROWS-1-r] = FULL;
  endtask

  task automatic load_grid();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic chk_grid(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++) if (grid[r] !== expg[r]) bad++;
    chk(tag, bad, 0);
  endtask

  // Returns the number of edges from the start edge (counted as 1) to done.
  task automatic run_pass(output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    if (!done) chk("pass_timeout", done, 1);
  endtask

  task automatic end_pass();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic score_pass(input int k, input int exp_cyc);
    int cyc;
    stack_full(k);
    load_grid();
    run_pass(cyc);
    chk("sat_cyc", cyc, exp_cyc);
    end_pass();
  endtask

  initial begin
    int cyc, w0, bad;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_row", rd_row, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_lines", lines, 0);
    chk("rst_score", score, 0);
    rst_n = 1'b1;

    // empty grid
    clear_img(); load_grid();
    w0 = wr_cnt;
    run_pass(cyc);
    chk("empty_cyc", cyc, 23);
    end_pass();
    chk("empty_writes", wr_cnt - w0, 0);
    chk("empty_lines", lines, 0);
    chk("empty_score", score, 0);
    chk("empty_idle", busy, 0);

    // single clear with shifting rows
    clear_img();
    img[21] = FULL; img[20] = P; img[0] = Q;
    expg[21] = P; expg[1] = Q;
    load_grid();
    w0 = wr_cnt;
    run_pass(cyc);
    chk("one_cyc", cyc, 24);
    end_pass();
    chk("one_writes", wr_cnt - w0, 22);
    chk("one_lines", lines, 1);
    chk("one_score", score, 1);
    chk_grid("one_grid");

    // four clears
    stack_full(4);
    img[17] = P; img[0] = Q;
    expg[21] = P; expg[4] = Q;
    load_grid();
    w0 = wr_cnt;
    run_pass(cyc);
    chk("four_cyc", cyc, 27);
    end_pass();
    chk("four_writes", wr_cnt - w0, 22);
    chk("four_lines", lines, 4);
    chk("four_score", score, 9);
    chk_grid("four_grid");

    // reset in the middle of SCAN
    clear_img(); img[21] = FULL; img[20] = P;
    load_grid();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_rd_row", rd_row, 0);
    chk("mid_rst_score", score, 0);
    w0 = wr_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_writes", wr_cnt - w0, 0);
    chk("mid_rst_idle", busy, 0);
    clear_img(); img[21] = FULL; img[20] = P;
    expg[21] = P;
    load_grid();
    run_pass(cyc);
    chk("post_rst_cyc", cyc, 24);
    end_pass();
    chk("post_rst_lines", lines, 1);
    chk("post_rst_score", score, 1);
    chk_grid("post_rst_grid");

    // score_clr coincident with DONE, start pulsed while busy
    stack_full(1); load_grid();
    @(negedge clk); start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); start = 1'b0;
    while (!done && cyc < 200) begin
      start = (cyc == 5);
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("clr_cyc", cyc, 24);
    chk("clr_busy_in_done", busy, 1);
    score_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    score_clr = 1'b0;
    chk("clr_score", score, 0);
    chk("clr_lines", lines, 1);
    chk("clr_busy_drop", busy, 0);
    bad = 0;
    repeat (30) begin @(negedge clk); if (busy) bad++; end
    chk("start_ignored", bad, 0);

    // illegal five-row clear scores as four
    stack_full(5); load_grid();
    w0 = wr_cnt;
    run_pass(cyc);
    chk("five_cyc", cyc, 28);
    end_pass();
    chk("five_writes", wr_cnt - w0, 22);
    chk("five_lines", lines, 4);
    chk("five_score", score, 8);
    chk_grid("five_grid");

    // idle score clear
    @(negedge clk); score_clr = 1'b1;
    @(negedge clk); score_clr = 1'b0;
    chk("idle_clr_score", score, 0);

    // point table and saturation
    score_pass(2, 25);
    chk("two_lines", lines, 2);
    chk("two_score", score, 3);
    score_pass(3, 26);
    chk("three_lines", lines, 3);
    chk("three_score", score, 8);
    for (int i = 0; i < 30; i++) score_pass(4, 27);
    chk("acc_248", score, 248);
    score_pass(1, 24);
    score_pass(1, 24);
    chk("acc_250", score, 250);
    score_pass(4, 27);
    chk("sat_255", score, 255);
    chk("sat_lines", lines, 4);
    score_pass(1, 24);
    chk("sat_hold", score, 255);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
